// File: rtl/pwm_audio_fifo.sv
`default_nettype none
// ==== pwm_audio_fifo: sample FIFO paced by a DIV-cycle tick, feeding a glitch-free PWM ====
// ==== Rev 1.0 -- define PWM_SIGMA_DELTA_EN for a first-order delta-sigma output instead ====
module pwm_audio_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int DIV        = 400
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                WR,
   input  logic [7:0]          WDATA,
   input  logic                CLRERR,
   output logic                PWM,
   output logic                FULL,
   output logic                EMPTY,
   output logic [DEPTH_LOG2:0] LEVEL,
   output logic                UNDERRUN,
   output logic                OVERRUN
);
   localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
   localparam logic [15:0]         TICK_LAST  = 16'(DIV - 1);
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [15:0]           tcnt;
   logic                  tick;
   logic                  pop;
   logic                  push;
   logic                  underrun_evt;
   logic                  overrun_evt;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   level_next;
   logic [7:0]            mem [DEPTH];
   logic [7:0]            sample;
   logic [7:0]            active;

   assign tick         = (tcnt == TICK_LAST);
   assign pop          = tick && !EMPTY;
   // A full FIFO still accepts on a tick because the pop frees a slot on the same edge.
   assign push         = WR && (!FULL || tick);
   assign underrun_evt = tick && EMPTY;
   assign overrun_evt  = WR && FULL && !tick;

   always_comb begin
      level_next = LEVEL;
      if (push && !pop) begin
         level_next = LEVEL + LEVEL_ONE;
      end else if (pop && !push) begin
         level_next = LEVEL - LEVEL_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         tcnt     <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         LEVEL    <= '0;
         EMPTY    <= 1'b1;
         FULL     <= 1'b0;
         UNDERRUN <= 1'b0;
         OVERRUN  <= 1'b0;
         sample   <= 8'h80;
      end else begin
         tcnt <= tick ? '0 : tcnt + 16'd1;
         if (pop) begin
            sample <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         LEVEL <= level_next;
         EMPTY <= (level_next == '0);
         FULL  <= (level_next == LEVEL_FULL);
         // Error events take priority over a same-cycle clear.
         if (underrun_evt) begin
            UNDERRUN <= 1'b1;
         end else if (CLRERR) begin
            UNDERRUN <= 1'b0;
         end
         if (overrun_evt) begin
            OVERRUN <= 1'b1;
         end else if (CLRERR) begin
            OVERRUN <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !RESET) begin
         mem[wr_ptr] <= WDATA;
      end
   end

`ifdef PWM_SIGMA_DELTA_EN
   logic [7:0] acc;
   logic [8:0] acc_sum;

   assign acc_sum = {1'b0, acc} + {1'b0, active};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc    <= '0;
         active <= 8'h80;
         PWM    <= 1'b0;
      end else begin
         acc    <= acc_sum[7:0];
         PWM    <= acc_sum[8];
         active <= sample;
      end
   end
`else
   logic [7:0] pcnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pcnt   <= '0;
         active <= 8'h80;
         PWM    <= 1'b0;
      end else begin
         pcnt <= pcnt + 8'd1;
         // Reload only at the period boundary so no period is ever truncated.
         if (pcnt == 8'hFF) begin
            active <= sample;
         end
         PWM <= (pcnt < active);
      end
   end
`endif

endmodule
`default_nettype wire
